// File: rtl/bp_mmio_cmd_arbiter.sv
// bp_mmio_cmd_arbiter: round-robin MMIO command arbiter with per-requester credits and in-order response steering
module bp_mmio_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 576,
  parameter int max_outstanding_p = 8,
  parameter int req_credits_p     = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0]       req_cmd_i,
  input  logic [num_req_p-1:0]                   req_cmd_v_i,
  output logic [num_req_p-1:0]                   req_cmd_ready_o,
  output logic [msg_width_p-1:0]                 req_resp_o,
  output logic [num_req_p-1:0]                   req_resp_v_o,
  input  logic [num_req_p-1:0]                   req_resp_yumi_i,
  output logic [msg_width_p-1:0]                 mmio_cmd_o,
  output logic                                   mmio_cmd_v_o,
  input  logic                                   mmio_cmd_ready_i,
  input  logic [msg_width_p-1:0]                 mmio_resp_i,
  input  logic                                   mmio_resp_v_i,
  output logic                                   mmio_resp_yumi_o,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                                   error_o
);
  localparam int ptr_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cred_w_lp = $clog2(req_credits_p+1);
  localparam int cnt_w_lp  = $clog2(max_outstanding_p+1);
  localparam int addr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  logic [ptr_w_lp-1:0]  rr_q, rr_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic [addr_w_lp-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ptr_w_lp-1:0]  tag_q [max_outstanding_p];
  logic [cred_w_lp-1:0] credit_q [num_req_p];
  logic [cred_w_lp-1:0] credit_d [num_req_p];
  logic                 error_q, error_d;
  logic [num_req_p-1:0] elig;
  logic [ptr_w_lp-1:0]  grant, head;
  logic                 any_elig, full, empty, grant_v, issue, resp_v, pop;
  always_comb begin
    for (int k = 0; k < num_req_p; k++) elig[k] = req_cmd_v_i[k] & (credit_q[k] != '0);
  end
  // Scan from farthest to nearest so the nearest eligible requester after rr_q wins
  always_comb begin
    grant    = rr_q;
    any_elig = 1'b0;
    for (int i = num_req_p-1; i >= 0; i--) begin
      if (elig[ptr_w_lp'((int'(rr_q) + i) % num_req_p)]) begin
        grant    = ptr_w_lp'((int'(rr_q) + i) % num_req_p);
        any_elig = 1'b1;
      end
    end
  end
  assign empty            = cnt_q == '0;
  assign full             = cnt_q == cnt_w_lp'(max_outstanding_p);
  assign head             = tag_q[rd_q];
  assign resp_v           = mmio_resp_v_i & ~empty;
  assign req_resp_v_o     = resp_v ? num_req_p'(1) << head : '0;
  assign req_resp_o       = mmio_resp_i;
  assign pop              = resp_v & req_resp_yumi_i[head];
  assign mmio_resp_yumi_o = pop;
  // A same-cycle pop frees a slot, so a full FIFO can still accept a grant
  assign grant_v          = any_elig & (~full | pop);
  assign mmio_cmd_v_o     = grant_v;
  assign mmio_cmd_o       = req_cmd_i[grant*msg_width_p +: msg_width_p];
  assign issue            = grant_v & mmio_cmd_ready_i;
  assign req_cmd_ready_o  = issue ? num_req_p'(1) << grant : '0;
  assign outstanding_o    = cnt_q;
  assign error_o          = error_q;
  always_comb begin
    rr_d    = issue ? ((grant == ptr_w_lp'(num_req_p-1)) ? '0 : grant + 1'b1) : rr_q;
    wr_d    = issue ? ((wr_q == addr_w_lp'(max_outstanding_p-1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d    = pop ? ((rd_q == addr_w_lp'(max_outstanding_p-1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d   = cnt_q + cnt_w_lp'(issue) - cnt_w_lp'(pop);
    error_d = error_q | (mmio_resp_v_i & empty) | (|(req_resp_yumi_i & ~req_resp_v_o));
    for (int k = 0; k < num_req_p; k++)
      credit_d[k] = credit_q[k] - cred_w_lp'(issue && grant == ptr_w_lp'(k))
                                + cred_w_lp'(pop && head == ptr_w_lp'(k));
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q    <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      error_q <= 1'b0;
      for (int k = 0; k < num_req_p; k++) credit_q[k] <= cred_w_lp'(req_credits_p);
    end else begin
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      error_q  <= error_d;
      credit_q <= credit_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (issue) tag_q[wr_q] <= grant;
  end
  always_ff @(posedge clk_i) begin
    if (reset_n_i)
      for (int k = 0; k < num_req_p; k++) assert (credit_d[k] <= cred_w_lp'(req_credits_p));
  end
endmodule
